// File: rtl/decode_stage_v2.sv
// decode_stage_v2
//
// Decode stage between IF/ID and EX. It owns the ID/EX pipeline register and
// contains the register file with write-through bypass, the immediate
// generator, load-use stall detection, branch/jump flush handling, and a
// req/ack handshake that stalls the front end for the cache-switch (CSW)
// instruction.
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-low reset
//   id_valid            IF/ID holds a valid instruction
//   instruction         instruction in ID
//   id_pc               PC of the instruction in ID
//   wb_we/addr/data     writeback port into the register file
//   branch_jump_taken   EX resolved a taken branch/jump this cycle
//   switch_ack          cache controller finished the switch
//   hold_if             freeze PC and IF/ID (combinational)
//   flush_if            clear IF/ID (combinational)
//   switch_req          cache-switch request (registered)
//   switch_id           requested cache ID (registered)
//   ex_*                ID/EX register contents
//
// FSM states
//   state  | meaning
//   S_IDLE | no cache switch outstanding
//   S_REQ  | switch_req raised, front end held until switch_ack or a flush

module decode_stage_v2 #(
   parameter int         XLEN       = 32,
   parameter int         NUM_REGS   = 32,
   parameter int         SW_ID_W    = 3,
   parameter logic [6:0] CSW_OPCODE = 7'b0001011
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [31:0]         instruction,
   input  logic [XLEN-1:0]     id_pc,
   input  logic                wb_we,
   input  logic [4:0]          wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                branch_jump_taken,
   input  logic                switch_ack,
   output logic                hold_if,
   output logic                flush_if,
   output logic                switch_req,
   output logic [SW_ID_W-1:0]  switch_id,
   output logic                ex_valid,
   output logic [XLEN-1:0]     ex_pc,
   output logic [XLEN-1:0]     ex_rs1_data,
   output logic [XLEN-1:0]     ex_rs2_data,
   output logic [XLEN-1:0]     ex_imm,
   output logic [4:0]          ex_rd,
   output logic [6:0]          ex_opcode,
   output logic [2:0]          ex_funct3,
   output logic [6:0]          ex_funct7
);

   localparam int          RIDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] NUM_REGS_U = NUM_REGS;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   // What the ID/EX register captures at the next edge.
   typedef enum logic [1:0] {
      SEL_BUBBLE = 2'd0,
      SEL_DECODE = 2'd1,
      SEL_CSW    = 2'd2
   } idex_sel_t;

   state_t    state;
   state_t    state_nxt;
   idex_sel_t idex_sel;
   logic      csw_launch;

   // ---------------------------------------------------------------------
   // Field extraction
   // ---------------------------------------------------------------------
   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] funct7;

   assign opcode = instruction[6:0];
   assign rd     = instruction[11:7];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign funct7 = instruction[31:25];

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wb_hit;
   logic            rs1_in_range;
   logic            rs2_in_range;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;

   // Out-of-range addresses behave like x0: never written, always read 0.
   assign wb_hit       = wb_we && (wb_addr != 5'd0) && ({27'd0, wb_addr} < NUM_REGS_U);
   assign rs1_in_range = ({27'd0, rs1} < NUM_REGS_U);
   assign rs2_in_range = ({27'd0, rs2} < NUM_REGS_U);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_hit) begin
         regs[wb_addr[RIDX_W-1:0]] <= wb_data;
      end
   end

   // Write-through: a register being written this cycle reads the new value.
   always_comb begin
      rs1_data = '0;
      if (rs1 != 5'd0 && rs1_in_range) begin
         if (wb_hit && wb_addr == rs1) begin
            rs1_data = wb_data;
         end else begin
            rs1_data = regs[rs1[RIDX_W-1:0]];
         end
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2 != 5'd0 && rs2_in_range) begin
         if (wb_hit && wb_addr == rs2) begin
            rs2_data = wb_data;
         end else begin
            rs2_data = regs[rs2[RIDX_W-1:0]];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Immediate generator
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] imm;

   always_comb begin
      imm = '0;
      case (opcode)
         OP_LOAD, OP_OPIMM, OP_JALR, CSW_OPCODE:
            imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
         OP_STORE:
            imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
         OP_BRANCH:
            imm = {{(XLEN-12){instruction[31]}}, instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'd0};
         OP_JAL:
            imm = {{(XLEN-20){instruction[31]}}, instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load-use hazard against the instruction currently in ID/EX
   // ---------------------------------------------------------------------
   logic uses_rs1;
   logic uses_rs2;
   logic load_use;

   assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign uses_rs2 = (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);

   assign load_use = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                     ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));

   // ---------------------------------------------------------------------
   // Switch FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Switch FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!branch_jump_taken && !load_use && id_valid && opcode == CSW_OPCODE) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // A flush aborts the request just like an acknowledge ends it.
            if (branch_jump_taken || switch_ack) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Switch FSM / pipeline control outputs, highest priority first
   // ---------------------------------------------------------------------
   always_comb begin
      hold_if    = 1'b0;
      flush_if   = 1'b0;
      idex_sel   = SEL_DECODE;
      csw_launch = 1'b0;
      if (!reset) begin
         idex_sel = SEL_BUBBLE;
      end else if (branch_jump_taken) begin
         flush_if = 1'b1;
         idex_sel = SEL_BUBBLE;
      end else if (state == S_REQ) begin
         if (switch_ack) begin
            idex_sel = SEL_CSW;
         end else begin
            hold_if  = 1'b1;
            idex_sel = SEL_BUBBLE;
         end
      end else if (load_use) begin
         hold_if  = 1'b1;
         idex_sel = SEL_BUBBLE;
      end else if (id_valid && opcode == CSW_OPCODE) begin
         hold_if    = 1'b1;
         idex_sel   = SEL_BUBBLE;
         csw_launch = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Request outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         switch_req <= 1'b0;
         switch_id  <= '0;
      end else begin
         switch_req <= (state_nxt == S_REQ);
         if (csw_launch) begin
            switch_id <= instruction[20 +: SW_ID_W];
         end
      end
   end

   // ---------------------------------------------------------------------
   // ID/EX register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset || idex_sel == SEL_BUBBLE) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7   <= '0;
      end else begin
         // The acknowledged CSW retires as a no-op, so it never writes a register.
         ex_valid    <= (idex_sel == SEL_CSW) ? 1'b1 : id_valid;
         ex_rd       <= (idex_sel == SEL_CSW) ? 5'd0 : rd;
         ex_pc       <= id_pc;
         ex_rs1_data <= rs1_data;
         ex_rs2_data <= rs2_data;
         ex_imm      <= imm;
         ex_opcode   <= opcode;
         ex_funct3   <= funct3;
         ex_funct7   <= funct7;
      end
   end

endmodule

// File: tb/tb_decode_stage_v2.sv
// Testbench for decode_stage_v2: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against a behavioural model.

module tb_decode_stage_v2;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] CSW    = 7'b0001011;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] instruction;
   logic [31:0] id_pc;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        branch_jump_taken;
   logic        switch_ack;
   logic        hold_if;
   logic        flush_if;
   logic        switch_req;
   logic [2:0]  switch_id;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;

   always #5 clk = ~clk;

   decode_stage_v2 dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .instruction(instruction),
      .id_pc(id_pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .branch_jump_taken(branch_jump_taken), .switch_ack(switch_ack),
      .hold_if(hold_if), .flush_if(flush_if), .switch_req(switch_req),
      .switch_id(switch_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7(ex_funct7)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [31:0] m_regs [32];
   logic        m_req;
   logic [2:0]  m_id;
   logic        m_valid;
   logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
   logic [4:0]  m_rd;
   logic [6:0]  m_op, m_f7;
   logic [2:0]  m_f3;
   bit          model_ok = 1'b0;

   function automatic logic [31:0] imm_of(input logic [31:0] ins);
      case (ins[6:0])
         LOAD, OPIMM, JALR, CSW: return {{20{ins[31]}}, ins[31:20]};
         STORE:                  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         BRANCH:                 return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         LUI, AUIPC:             return {ins[31:12], 12'd0};
         JAL:                    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rdreg(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   initial begin
      logic [6:0]  op;
      logic [4:0]  r1, r2;
      logic        u1, u2, lu, e_hold, e_flush, n_req, was_reset;
      logic [2:0]  n_id;
      int          kind;
      logic        n_valid;
      logic [31:0] n_pc, n_rs1, n_rs2, n_imm;
      logic [4:0]  n_rd;
      logic [6:0]  n_op, n_f7;
      logic [2:0]  n_f3;
      logic        w_en;
      logic [4:0]  w_a;
      logic [31:0] w_d;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_req = 0; m_id = 0; m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
      m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
      forever begin
         @(negedge clk); #1;
         op = instruction[6:0];
         r1 = instruction[19:15];
         r2 = instruction[24:20];
         u1 = !(op == LUI || op == AUIPC || op == JAL);
         u2 = (op == OP || op == STORE || op == BRANCH);
         lu = m_valid && m_op == LOAD && m_rd != 0 &&
              ((u1 && m_rd == r1) || (u2 && m_rd == r2));
         e_hold = 0; e_flush = 0; n_req = m_req; n_id = m_id; kind = 0;
         was_reset = !reset;
         if (!reset) begin
            n_req = 0; n_id = 0;
         end else if (branch_jump_taken) begin
            e_flush = 1; n_req = 0;
         end else if (m_req) begin
            if (switch_ack) begin kind = 2; n_req = 0; end
            else e_hold = 1;
         end else if (lu) begin
            e_hold = 1;
         end else if (id_valid && op == CSW) begin
            e_hold = 1; n_req = 1; n_id = instruction[22:20];
         end else begin
            kind = 1;
         end
         if (model_ok) begin
            check("hold_if", {31'd0, hold_if}, {31'd0, e_hold});
            check("flush_if", {31'd0, flush_if}, {31'd0, e_flush});
         end
         n_valid = (kind == 2) ? 1'b1 : id_valid;
         n_pc = id_pc; n_rs1 = rdreg(r1); n_rs2 = rdreg(r2); n_imm = imm_of(instruction);
         n_rd = (kind == 2) ? 5'd0 : instruction[11:7];
         n_op = op; n_f3 = instruction[14:12]; n_f7 = instruction[31:25];
         if (kind == 0) begin
            n_valid = 0; n_pc = 0; n_rs1 = 0; n_rs2 = 0; n_imm = 0;
            n_rd = 0; n_op = 0; n_f3 = 0; n_f7 = 0;
         end
         w_en = reset && wb_we && wb_addr != 0; w_a = wb_addr; w_d = wb_data;
         @(posedge clk); #2;
         if (was_reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         end else if (w_en) begin
            m_regs[w_a] = w_d;
         end
         m_req = n_req; m_id = n_id;
         m_valid = n_valid; m_pc = n_pc; m_rs1 = n_rs1; m_rs2 = n_rs2; m_imm = n_imm;
         m_rd = n_rd; m_op = n_op; m_f3 = n_f3; m_f7 = n_f7;
         if (was_reset) model_ok = 1'b1;
         if (model_ok) begin
            check("switch_req", {31'd0, switch_req}, {31'd0, m_req});
            check("switch_id", {29'd0, switch_id}, {29'd0, m_id});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            check("ex_pc", ex_pc, m_pc);
            check("ex_rs1_data", ex_rs1_data, m_rs1);
            check("ex_rs2_data", ex_rs2_data, m_rs2);
            check("ex_imm", ex_imm, m_imm);
            check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            check("ex_opcode", {25'd0, ex_opcode}, {25'd0, m_op});
            check("ex_funct3", {29'd0, ex_funct3}, {29'd0, m_f3});
            check("ex_funct7", {25'd0, ex_funct7}, {25'd0, m_f7});
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; instruction = 32'h00000013; id_pc = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; branch_jump_taken = 0; switch_ack = 0;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      id_valid = 1; instruction = ins; id_pc = pc;
   endtask

   task automatic randomize_inputs();
      id_valid = 1'($urandom); instruction = $urandom; id_pc = $urandom;
      wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      branch_jump_taken = 1'($urandom); switch_ack = 1'($urandom);
   endtask

   logic [6:0] ops [10] = '{LOAD, OPIMM, JALR, CSW, STORE, BRANCH, LUI, AUIPC, JAL, OP};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hcnt, rcnt;
      logic [31:0] ins;

      // Reset with random inputs
      reset = 0; randomize_inputs();
      tick();
      randomize_inputs(); #1;
      check("rst_hold_if", {31'd0, hold_if}, 32'd0);
      check("rst_flush_if", {31'd0, flush_if}, 32'd0);
      tick();
      check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_ex_pc", ex_pc, 32'd0);
      check("rst_ex_imm", ex_imm, 32'd0);
      check("rst_switch_req", {31'd0, switch_req}, 32'd0);
      reset = 1; idle_inputs();
      issue(32'h000283B3, 32'h10);            // add x7,x5,x0
      tick();
      check("x5_after_reset", ex_rs1_data, 32'd0);
      check("add_rd", {27'd0, ex_rd}, 32'd7);

      // Bypass and x0
      wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      tick();
      check("bypass_rs1", ex_rs1_data, 32'hDEADBEEF);
      wb_we = 0;
      tick();
      check("regfile_x5", ex_rs1_data, 32'hDEADBEEF);
      issue(32'h000003B3, 32'h14);            // add x7,x0,x0
      wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
      tick();
      check("x0_bypass_zero", ex_rs1_data, 32'd0);
      wb_we = 0;
      tick();
      check("x0_read_zero", ex_rs1_data, 32'd0);
      issue(32'h005003B3, 32'h18);            // add x7,x0,x5
      wb_we = 1; wb_addr = 5; wb_data = 32'h000055AA;
      tick();
      check("bypass_rs2", ex_rs2_data, 32'h000055AA);
      wb_we = 0;

      // Load-use
      issue(32'h0000A183, 32'h100);           // lw x3,0(x1)
      tick();
      issue(32'h00218233, 32'h104);           // add x4,x3,x2
      #1; check("lu_hold", {31'd0, hold_if}, 32'd1);
      tick();
      check("lu_bubble", {31'd0, ex_valid}, 32'd0);
      #1; check("lu_hold_released", {31'd0, hold_if}, 32'd0);
      tick();
      check("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
      check("lu_issue_rd", {27'd0, ex_rd}, 32'd4);
      check("lu_issue_pc", ex_pc, 32'h104);
      issue(32'h0000A183, 32'h108);
      tick();
      issue(32'h00001237, 32'h10C);           // lui x4,1
      #1; check("lui_no_stall", {31'd0, hold_if}, 32'd0);
      tick();
      check("lui_valid", {31'd0, ex_valid}, 32'd1);

      // Immediates
      issue(32'hFE20AE23, 32'h110); tick();   // sw x2,-4(x1)
      check("imm_s", ex_imm, 32'hFFFFFFFC);
      issue(32'h001000EF, 32'h114); tick();   // jal x1,+2048
      check("imm_j", ex_imm, 32'h00000800);
      issue(32'hABCDE0B7, 32'h118); tick();   // lui x1,0xABCDE
      check("imm_u", ex_imm, 32'hABCDE000);
      issue(32'hFE208CE3, 32'h11C); tick();   // beq x1,x2,-8
      check("imm_b", ex_imm, 32'hFFFFFFF8);
      issue(32'h00218233, 32'h120); tick();
      check("imm_r", ex_imm, 32'd0);

      // Cache switch with ack in the fourth S_REQ cycle
      hcnt = 0; rcnt = 0;
      issue(32'h0050048B, 32'h200);           // CSW imm=5, rd=9
      #1; if (hold_if) hcnt++;
      tick();
      check("csw_req_rise", {31'd0, switch_req}, 32'd1);
      check("csw_id", {29'd0, switch_id}, 32'd5);
      check("csw_entry_bubble", {31'd0, ex_valid}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         #1; if (hold_if) hcnt++; if (switch_req) rcnt++;
         tick();
         check("csw_wait_bubble", {31'd0, ex_valid}, 32'd0);
      end
      switch_ack = 1;
      #1; check("csw_ack_hold", {31'd0, hold_if}, 32'd0);
      tick();
      check("csw_req_fall", {31'd0, switch_req}, 32'd0);
      check("csw_issue_valid", {31'd0, ex_valid}, 32'd1);
      check("csw_issue_rd", {27'd0, ex_rd}, 32'd0);
      check("csw_issue_op", {25'd0, ex_opcode}, 32'h0B);
      check("csw_issue_pc", ex_pc, 32'h200);
      check("csw_hold_cycles", hcnt, 32'd4);
      check("csw_wait_cycles", rcnt, 32'd3);
      switch_ack = 0; id_valid = 0;
      tick();

      // Flush beats CSW entry
      issue(32'h0050048B, 32'h300); branch_jump_taken = 1;
      #1; check("flush_entry_flush", {31'd0, flush_if}, 32'd1);
      check("flush_entry_hold", {31'd0, hold_if}, 32'd0);
      tick();
      check("flush_entry_req", {31'd0, switch_req}, 32'd0);
      check("flush_entry_bubble", {31'd0, ex_valid}, 32'd0);
      // Flush aborts S_REQ
      branch_jump_taken = 0;
      tick();
      check("abort_req_up", {31'd0, switch_req}, 32'd1);
      tick();
      branch_jump_taken = 1;
      #1; check("abort_flush", {31'd0, flush_if}, 32'd1);
      tick();
      check("abort_req_drop", {31'd0, switch_req}, 32'd0);
      branch_jump_taken = 0; id_valid = 0; switch_ack = 1;
      #1; check("idle_ack_hold", {31'd0, hold_if}, 32'd0);
      tick();
      check("idle_ack_req", {31'd0, switch_req}, 32'd0);
      switch_ack = 0;

      // Reset during an outstanding switch
      issue(32'h0070048B, 32'h400);           // CSW imm=7
      tick();
      check("rst_sreq_up", {31'd0, switch_req}, 32'd1);
      reset = 0;
      #1; check("rst_sreq_hold", {31'd0, hold_if}, 32'd0);
      tick();
      check("rst_sreq_req", {31'd0, switch_req}, 32'd0);
      check("rst_sreq_id", {29'd0, switch_id}, 32'd0);
      reset = 1; idle_inputs();
      tick();

      // Random traffic checked by the model
      for (int c = 0; c < 300; c++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 9)];
         ins[11:7] = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         id_valid = ($urandom_range(0, 9) < 8);
         instruction = ins; id_pc = $urandom;
         wb_we = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
         branch_jump_taken = ($urandom_range(0, 19) == 0);
         switch_ack = ($urandom_range(0, 9) < 3);
         tick();
      end
      idle_inputs();
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
